// File: rtl/i2s_receiver.sv
// Slave-mode I2S deserializer: oversamples sck/lrck/sdout on the system clock and
// rebuilds WIDTH-bit left/right PCM pairs, emitting each complete pair with a one-cycle strobe.
module i2s_receiver #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             audio_sck,
    input  logic             audio_lrck,
    input  logic             audio_sdout,
    output logic [WIDTH-1:0] audio_out_left,
    output logic [WIDTH-1:0] audio_out_right,
    output logic             sample_valid,
    output logic             locked
);

    localparam int                CNT_W   = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sck_meta_q, sck_sync_q, sck_d_q;
    logic             lrck_meta_q, lrck_sync_q;
    logic             sdout_meta_q, sdout_sync_q;
    logic             sck_rise;

    logic             lrck_prev_q, lrck_prev_d;
    logic             chan_q, chan_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] left_hold_q, left_hold_d;
    logic             left_ok_q, left_ok_d;
    logic [WIDTH-1:0] out_left_q, out_left_d;
    logic [WIDTH-1:0] out_right_q, out_right_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic [WIDTH-1:0] word;

    assign sck_rise = sck_sync_q & ~sck_d_q;

    always_comb begin
        lrck_prev_d = lrck_prev_q;
        chan_d      = chan_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        word        = {shift_q[WIDTH-2:0], sdout_sync_q};

        if (sck_rise) begin
            lrck_prev_d = lrck_sync_q;
            // A word-select change opens a new channel; its first bit is the I2S delay slot.
            if (lrck_sync_q != lrck_prev_q) begin
                bit_cnt_d = '0;
                chan_d    = lrck_sync_q;
                locked_d  = 1'b1;
                if (!lrck_sync_q) begin
                    left_ok_d = 1'b0;
                end
            end else if (locked_q && (bit_cnt_q < CNT_MAX)) begin
                shift_d   = word;
                bit_cnt_d = bit_cnt_q + CNT_ONE;
                if (bit_cnt_q == CNT_END) begin
                    if (!chan_q) begin
                        left_hold_d = word;
                        left_ok_d   = 1'b1;
                    end else if (left_ok_q) begin
                        out_left_d  = left_hold_q;
                        out_right_d = word;
                        valid_d     = 1'b1;
                        left_ok_d   = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_meta_q   <= 1'b0;
            sck_sync_q   <= 1'b0;
            sck_d_q      <= 1'b0;
            lrck_meta_q  <= 1'b0;
            lrck_sync_q  <= 1'b0;
            sdout_meta_q <= 1'b0;
            sdout_sync_q <= 1'b0;
            lrck_prev_q  <= 1'b0;
            chan_q       <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_hold_q  <= '0;
            left_ok_q    <= 1'b0;
            out_left_q   <= '0;
            out_right_q  <= '0;
            valid_q      <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            sck_meta_q   <= audio_sck;
            sck_sync_q   <= sck_meta_q;
            sck_d_q      <= sck_sync_q;
            lrck_meta_q  <= audio_lrck;
            lrck_sync_q  <= lrck_meta_q;
            sdout_meta_q <= audio_sdout;
            sdout_sync_q <= sdout_meta_q;
            lrck_prev_q  <= lrck_prev_d;
            chan_q       <= chan_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_hold_q  <= left_hold_d;
            left_ok_q    <= left_ok_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
            valid_q      <= valid_d;
            locked_q     <= locked_d;
        end
    end

    assign audio_out_left  = out_left_q;
    assign audio_out_right = out_right_q;
    assign sample_valid    = valid_q;
    assign locked          = locked_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives 32-sck I2S slots at 16 clk per sck and checks
// each captured stereo pair, its latency and spacing, against hand-computed values.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        audio_sck;
    logic        audio_lrck;
    logic        audio_sdout;
    logic [15:0] audio_out_left;
    logic [15:0] audio_out_right;
    logic        sample_valid;
    logic        locked;

    i2s_receiver #(.WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .audio_sck      (audio_sck),
        .audio_lrck     (audio_lrck),
        .audio_sdout    (audio_sdout),
        .audio_out_left (audio_out_left),
        .audio_out_right(audio_out_right),
        .sample_valid   (sample_valid),
        .locked         (locked)
    );

    always #5 clk = ~clk;

    int cycleCount = 0;
    always @(posedge clk) cycleCount++;

    // Every cycle with sample_valid high is logged, so a stretched pulse shows up as an extra entry.
    logic [15:0] qLeft[$];
    logic [15:0] qRight[$];
    int          qCycle[$];
    always @(negedge clk) begin
        if (sample_valid) begin
            qLeft.push_back(audio_out_left);
            qRight.push_back(audio_out_right);
            qCycle.push_back(cycleCount);
        end
    end

    int checks = 0;
    int errors = 0;
    int lastRiseCycle = 0;
    int rightLsbCycle = 0;
    int base;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic checkPair(input string tag, input int idx, input logic [15:0] l, input logic [15:0] r);
        checkOutput({tag, "_present"}, 32'(qLeft.size() > idx), 32'd1);
        if (qLeft.size() > idx) begin
            checkOutput({tag, "_left"}, 32'(qLeft[idx]), 32'(l));
            checkOutput({tag, "_right"}, 32'(qRight[idx]), 32'(r));
        end
    endtask

    task automatic sckBit(input logic ch, input logic d);
        @(negedge clk);
        audio_sck   = 1'b0;
        audio_lrck  = ch;
        audio_sdout = d;
        repeat (8) @(negedge clk);
        audio_sck     = 1'b1;
        lastRiseCycle = cycleCount;
        repeat (7) @(negedge clk);
    endtask

    // Slot bit 0 is the delay bit, bits 1..16 carry the word MSB first, the rest is padding.
    task automatic sendSlot(input logic ch, input logic [15:0] w, input int nsck, input logic pad, input int startBit);
        logic d;
        for (int k = startBit; k < nsck; k++) begin
            d = (k >= 1 && k <= 16) ? w[16-k] : pad;
            sckBit(ch, d);
            if (ch && k == 16) rightLsbCycle = lastRiseCycle;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r);
        sendSlot(1'b0, l, 32, 1'b1, 0);
        sendSlot(1'b1, r, 32, 1'b1, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        audio_sck   = 1'b0;
        audio_lrck  = 1'b0;
        audio_sdout = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) sckBit(i[0], ~i[0]);
        checkOutput("rst_left", 32'(audio_out_left), 32'h0);
        checkOutput("rst_right", 32'(audio_out_right), 32'h0);
        checkOutput("rst_locked", 32'(locked), 32'h0);
        checkOutput("rst_no_pulse", 32'(qLeft.size()), 32'd0);

        @(negedge clk);
        audio_sck = 1'b0; audio_lrck = 1'b0; audio_sdout = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("locked_before_edge", 32'(locked), 32'h0);
        sendSlot(1'b1, 16'hFFFF, 4, 1'b0, 0);
        checkOutput("locked_after_edge", 32'(locked), 32'h1);
        checkOutput("leadin_no_pulse", 32'(qLeft.size()), 32'd0);

        applyStimulus(16'h8001, 16'h7FFE);
        checkOutput("single_count", 32'(qLeft.size()), 32'd1);
        checkPair("single", 0, 16'h8001, 16'h7FFE);
        if (qCycle.size() > 0) checkOutput("single_latency", 32'(qCycle[0]), 32'(rightLsbCycle + 3));
        checkOutput("single_hold_left", 32'(audio_out_left), 32'h8001);
        checkOutput("single_valid_low", 32'(sample_valid), 32'h0);

        base = qLeft.size();
        for (int i = 0; i < 10; i++) applyStimulus(16'(i), ~16'(i));
        checkOutput("ten_count", 32'(qLeft.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            checkPair($sformatf("ten_%0d", i), base + i, 16'(i), ~16'(i));
            if (i > 0 && qCycle.size() > base + i)
                checkOutput($sformatf("ten_spacing_%0d", i), 32'(qCycle[base+i] - qCycle[base+i-1]), 32'd1024);
        end

        @(negedge clk);
        rst_n = 1'b0;
        audio_sck = 1'b0; audio_lrck = 1'b1; audio_sdout = 1'b0;
        #1;
        checkOutput("rst2_left", 32'(audio_out_left), 32'h0);
        checkOutput("rst2_locked", 32'(locked), 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        base = qLeft.size();
        sendSlot(1'b1, 16'hBEEF, 32, 1'b0, 12);
        applyStimulus(16'h1234, 16'h5678);
        applyStimulus(16'h9ABC, 16'hDEF0);
        checkOutput("midright_count", 32'(qLeft.size() - base), 32'd2);
        checkPair("midright_first", base, 16'h1234, 16'h5678);
        checkPair("midright_second", base + 1, 16'h9ABC, 16'hDEF0);

        base = qLeft.size();
        sendSlot(1'b0, 16'h5555, 8, 1'b1, 0);
        sendSlot(1'b1, 16'hAAAA, 32, 1'b1, 0);
        checkOutput("short_no_pulse", 32'(qLeft.size() - base), 32'd0);
        checkOutput("short_hold_left", 32'(audio_out_left), 32'h9ABC);
        checkOutput("short_hold_right", 32'(audio_out_right), 32'hDEF0);
        applyStimulus(16'h0F0F, 16'hF0F0);
        checkOutput("short_next_count", 32'(qLeft.size() - base), 32'd1);
        checkPair("short_next", base, 16'h0F0F, 16'hF0F0);

        base = qLeft.size();
        sendSlot(1'b0, 16'h3C3C, 10, 1'b1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst3_left", 32'(audio_out_left), 32'h0);
        checkOutput("rst3_right", 32'(audio_out_right), 32'h0);
        checkOutput("rst3_locked", 32'(locked), 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        sendSlot(1'b0, 16'h3C3C, 32, 1'b1, 10);
        checkOutput("rst3_still_unlocked", 32'(locked), 32'h0);
        sendSlot(1'b1, 16'h1111, 32, 1'b1, 0);
        checkOutput("rst3_locked_again", 32'(locked), 32'h1);
        checkOutput("rst3_no_pulse", 32'(qLeft.size() - base), 32'd0);
        applyStimulus(16'h4321, 16'h8765);
        checkOutput("rst3_count", 32'(qLeft.size() - base), 32'd1);
        checkPair("rst3_frame", base, 16'h4321, 16'h8765);

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
